// File: rtl/sensor_conditioner.sv
// sensor_conditioner: debounces the four active-low rider inputs and turns them
// into single-cycle event strobes. Fork/crank give one strobe per debounced
// activation; mode/trip are classified as short or long presses.
module sensor_conditioner #(
  parameter int DEBOUNCE_TICKS   = 64,
  parameter int LONG_PRESS_TICKS = 32768
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic nMode,
  input  logic nTrip,
  input  logic nFork,
  input  logic nCrank,
  output logic ForkPulse,
  output logic CrankPulse,
  output logic ModeShort,
  output logic TripShort,
  output logic ModeLong,
  output logic TripLong,
  output logic ModeHeld,
  output logic TripHeld
);

  localparam int DW = $clog2(DEBOUNCE_TICKS);
  localparam int HW = $clog2(LONG_PRESS_TICKS);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_TICKS - 1);

  // Channel order in the vectors below: 0 mode, 1 trip, 2 fork, 3 crank.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } btn_state_t;

  logic [3:0]    raw;
  logic [3:0]    stable;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    fall;
  logic [3:0]    rise;

  btn_state_t    btn_state [2];
  btn_state_t    btn_next  [2];
  logic [HW-1:0] hold_cnt  [2];
  logic [HW-1:0] hold_next [2];
  logic [1:0]    short_next;
  logic [1:0]    long_next;

  assign raw = {nCrank, nFork, nTrip, nMode};

  // Flag the edges at which a debounced state is about to flip, so strobes can
  // be registered at the same edge as the flip itself.
  always_comb begin
    fall = '0;
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      if ((raw[i] != stable[i]) && (db_cnt[i] == DB_LAST)) begin
        fall[i] = stable[i];
        rise[i] = ~stable[i];
      end
    end
  end

  // Debouncers: a raw level must disagree with the stable level for
  // DEBOUNCE_TICKS consecutive edges before it is accepted; any agreement clears.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stable <= '1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Fork and crank strobe only on the debounced press (1 -> 0) edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ForkPulse  <= 1'b0;
      CrankPulse <= 1'b0;
    end else begin
      ForkPulse  <= fall[2];
      CrankPulse <= fall[3];
    end
  end

  // Button FSM next-state: a release while HELD is a short press; reaching the
  // hold limit first is a long press and freezes the counter until release.
  always_comb begin
    short_next = '0;
    long_next  = '0;
    for (int b = 0; b < 2; b++) begin
      btn_next[b]  = btn_state[b];
      hold_next[b] = hold_cnt[b];
      case (btn_state[b])
        IDLE: begin
          if (fall[b]) begin
            btn_next[b]  = HELD;
            hold_next[b] = '0;
          end
        end
        HELD: begin
          if (rise[b]) begin
            btn_next[b]   = IDLE;
            short_next[b] = 1'b1;
          end else if (hold_cnt[b] == HOLD_LAST) begin
            btn_next[b]  = LONG;
            long_next[b] = 1'b1;
          end else begin
            hold_next[b] = hold_cnt[b] + HW'(1);
          end
        end
        LONG: begin
          if (rise[b]) btn_next[b] = IDLE;
        end
        default: begin
          btn_next[b] = IDLE;
        end
      endcase
    end
  end

  // Button FSM state, hold counters and registered button outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int b = 0; b < 2; b++) begin
        btn_state[b] <= IDLE;
        hold_cnt[b]  <= '0;
      end
      ModeShort <= 1'b0;
      TripShort <= 1'b0;
      ModeLong  <= 1'b0;
      TripLong  <= 1'b0;
      ModeHeld  <= 1'b0;
      TripHeld  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        btn_state[b] <= btn_next[b];
        hold_cnt[b]  <= hold_next[b];
      end
      ModeShort <= short_next[0];
      TripShort <= short_next[1];
      ModeLong  <= long_next[0];
      TripLong  <= long_next[1];
      ModeHeld  <= (btn_next[0] != IDLE);
      TripHeld  <= (btn_next[1] != IDLE);
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed and randomized stimulus against a
// time-stamp based reference model of the sensor conditioner.
module tb_sensor_conditioner;

  localparam int DB = 4;
  localparam int LP = 16;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b1;
  logic nMode   = 1'b1;
  logic nTrip   = 1'b1;
  logic nFork   = 1'b1;
  logic nCrank  = 1'b1;
  logic ForkPulse, CrankPulse, ModeShort, TripShort;
  logic ModeLong, TripLong, ModeHeld, TripHeld;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: run length of disagreement per input, and the cycle at
  // which each button press was accepted.
  bit m_stable    [4];
  int m_run       [4];
  int m_press     [2];
  bit m_long_done [2];
  bit e_fork, e_crank;
  bit e_short [2];
  bit e_long  [2];
  bit e_held  [2];

  sensor_conditioner #(
    .DEBOUNCE_TICKS  (DB),
    .LONG_PRESS_TICKS(LP)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .nMode     (nMode),
    .nTrip     (nTrip),
    .nFork     (nFork),
    .nCrank    (nCrank),
    .ForkPulse (ForkPulse),
    .CrankPulse(CrankPulse),
    .ModeShort (ModeShort),
    .TripShort (TripShort),
    .ModeLong  (ModeLong),
    .TripLong  (TripLong),
    .ModeHeld  (ModeHeld),
    .TripHeld  (TripHeld)
  );

  always #5 HCLK = ~HCLK;

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      m_stable[i] = 1'b1;
      m_run[i]    = 0;
    end
    for (int b = 0; b < 2; b++) begin
      m_press[b]     = 0;
      m_long_done[b] = 1'b0;
      e_short[b]     = 1'b0;
      e_long[b]      = 1'b0;
      e_held[b]      = 1'b0;
    end
    e_fork  = 1'b0;
    e_crank = 1'b0;
  endfunction

  // r = {nCrank, nFork, nTrip, nMode} as sampled at this rising edge.
  function automatic void modelStep(logic [3:0] r);
    bit fell [4];
    bit rose [4];
    cyc++;
    for (int i = 0; i < 4; i++) begin
      fell[i] = 1'b0;
      rose[i] = 1'b0;
      if (r[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = r[i];
          m_run[i]    = 0;
          if (r[i] == 1'b0) fell[i] = 1'b1;
          else              rose[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    e_fork  = fell[2];
    e_crank = fell[3];
    for (int b = 0; b < 2; b++) begin
      e_short[b] = 1'b0;
      e_long[b]  = 1'b0;
      if (fell[b]) begin
        m_press[b]     = cyc;
        m_long_done[b] = 1'b0;
      end else if (rose[b]) begin
        e_short[b] = !m_long_done[b];
      end else if (!m_stable[b] && !m_long_done[b] && (cyc - m_press[b] == LP)) begin
        e_long[b]      = 1'b1;
        m_long_done[b] = 1'b1;
      end
      e_held[b] = !m_stable[b];
    end
  endfunction

  task automatic checkOutput(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("ForkPulse",  ForkPulse,  e_fork);
    checkOutput("CrankPulse", CrankPulse, e_crank);
    checkOutput("ModeShort",  ModeShort,  e_short[0]);
    checkOutput("TripShort",  TripShort,  e_short[1]);
    checkOutput("ModeLong",   ModeLong,   e_long[0]);
    checkOutput("TripLong",   TripLong,   e_long[1]);
    checkOutput("ModeHeld",   ModeHeld,   e_held[0]);
    checkOutput("TripHeld",   TripHeld,   e_held[1]);
  endtask

  // Called at a falling edge; drives inputs, steps one rising edge, checks,
  // and returns at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input int n);
    for (int k = 0; k < n; k++) begin
      {nCrank, nFork, nTrip, nMode} = r;
      @(posedge HCLK);
      modelStep(r);
      #1;
      checkAll();
      @(negedge HCLK);
    end
  endtask

  // Holds reset for n rising edges while inputs stay at r; outputs must read 0.
  task automatic pulseReset(input logic [3:0] r, input int n);
    {nCrank, nFork, nTrip, nMode} = r;
    HRESETn = 1'b0;
    modelReset();
    #1;
    checkAll();
    for (int k = 0; k < n; k++) begin
      @(posedge HCLK);
      #1;
      checkAll();
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    logic [3:0] cur;
    int remain [4];
    modelReset();
    @(negedge HCLK);
    pulseReset(4'hF, 2);

    $display("[TB] glitch rejection");
    applyStimulus(4'b1011, 3);
    applyStimulus(4'hF, 1);
    applyStimulus(4'b1011, 3);
    applyStimulus(4'hF, 4);

    $display("[TB] clean fork");
    applyStimulus(4'b1011, 10);
    applyStimulus(4'hF, 8);

    $display("[TB] short press");
    applyStimulus(4'b1110, 8);
    applyStimulus(4'hF, 8);

    $display("[TB] long press");
    applyStimulus(4'b1101, 40);
    applyStimulus(4'hF, 8);

    $display("[TB] simultaneous fork and crank");
    applyStimulus(4'b0011, 6);
    applyStimulus(4'hF, 6);

    $display("[TB] reset mid-press");
    applyStimulus(4'b1110, 10);
    pulseReset(4'b1110, 3);
    applyStimulus(4'b1110, 25);
    applyStimulus(4'hF, 8);

    $display("[TB] randomized run");
    cur = 4'hF;
    for (int i = 0; i < 4; i++) remain[i] = $urandom_range(1, 20);
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (remain[i] == 0) begin
          cur[i]    = ~cur[i];
          remain[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                  : $urandom_range(4, 30);
        end
        remain[i]--;
      end
      if (t == 1000) pulseReset(cur, 2);
      applyStimulus(cur, 1);
    end
    applyStimulus(4'hF, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Debounces the four active-low rider inputs (nMode, nTrip, nFork, nCrank) after they enter comp_core and turns them into single-cycle event strobes for the measurement and display logic. Fork and crank sensors produce one strobe per debounced activation. Mode and trip buttons are classified as short press or long press. The block sits directly downstream of the top-level pad wrapper, which delivers the inputs already synchronised to HCLK. It sits upstream of the speed, cadence and mode-control logic.

## Interface
- DEBOUNCE_TICKS, 64: consecutive HCLK cycles a raw input must differ from its debounced state before the state changes; legal range ≥ 2.
- LONG_PRESS_TICKS, 32768: HCLK cycles a debounced button must stay pressed to count as a long press (1 s at 32.768 kHz); must exceed DEBOUNCE_TICKS.
- HCLK  input  1  core clock; all state changes on its rising edge.
- HRESETn  input  1  reset, asynchronous assert, active-low.
- nMode, nTrip, nFork, nCrank  input  1 each  synchronised raw inputs, low = active.
- ForkPulse  output  1  one-cycle strobe on each debounced fork activation.
- CrankPulse  output  1  one-cycle strobe on each debounced crank activation.
- ModeShort, TripShort  output  1 each  one-cycle strobe on release of a short press.
- ModeLong, TripLong  output  1 each  one-cycle strobe when a press reaches long duration.
- ModeHeld, TripHeld  output  1 each  debounced pressed level, high = pressed.

## Operation
- All outputs are registered.
- Reset values:
  - every pulse output is 0;
  - ModeHeld and TripHeld are 0;
  - all four debounced states are 1 (inactive);
  - all counters are 0;
  - both button FSMs are IDLE.
- Debouncer, one per input, identical:
  - Counter width is $clog2(DEBOUNCE_TICKS).
  - On each edge where raw ≠ stable: if the counter equals DEBOUNCE_TICKS−1, then stable <= raw and the counter clears; otherwise the counter increments.
  - On each edge where raw == stable, the counter clears. Any glitch shorter than DEBOUNCE_TICKS is therefore discarded completely.
- Fork and crank strobes:
  - ForkPulse / CrankPulse is registered high at the same edge where the debounced state goes 1→0.
  - A 0→1 transition produces no strobe.
- Button FSM, one each for mode and trip. Hold counter width is $clog2(LONG_PRESS_TICKS).
  - IDLE: when the debounced state goes to 0, move to HELD and clear the hold counter.
  - HELD, still pressed: the hold counter increments each cycle. When it equals LONG_PRESS_TICKS−1, move to LONG and strobe *Long for one cycle.
  - HELD, debounced release: move to IDLE and strobe *Short for one cycle.
  - LONG: the hold counter is frozen. On debounced release, move to IDLE with no strobe.
  - *Held = 1 while in HELD or LONG.
- Channels are fully independent. Simultaneous events on any set of inputs produce their strobes in the same cycle.

## Timing
- Debounce latency: a raw level change first sampled at edge k, and held, flips the stable state at edge k+DEBOUNCE_TICKS−1. The corresponding strobe is visible for the following cycle.
- Long-press latency: *Long is registered LONG_PRESS_TICKS edges after the edge at which the debounced press entered HELD.
- *Short is registered at the same edge as the debounced release.
- *Long and *Short are never high for the same channel in the same cycle. At most one of them fires per press.
- Reset mid-operation:
  - Everything returns to reset values immediately (asynchronous), and in-flight counts are lost.
  - An input still held low when HRESETn rises is debounced afresh. It fires ForkPulse/CrankPulse, or enters HELD, after DEBOUNCE_TICKS cycles.
- Counters never wrap: the debounce counter clears at terminal count, and the hold counter stops in LONG.

## Test plan
All scenarios use DEBOUNCE_TICKS=4 and LONG_PRESS_TICKS=16.
- Glitch rejection: nFork low for 3 cycles, then high → ForkPulse stays 0 and the debounce counter returns to 0.
- Clean fork: nFork low for 10 cycles → exactly one ForkPulse, high in the cycle after the 4th low-sampling edge. The later release produces no pulse.
- Short press: nMode low for 8 cycles, then high for 8 → ModeHeld rises after 4 cycles, ModeShort is a single pulse 4 cycles after release, ModeLong stays 0.
- Long press: nTrip low for 40 cycles → TripLong is a single pulse 16 cycles after TripHeld rose, TripShort is never asserted, and TripHeld falls 4 cycles after release.
- Simultaneous: nFork and nCrank fall on the same edge → ForkPulse and CrankPulse are high in the same single cycle.
- Reset mid-press: nMode low for 10 cycles, then HRESETn pulsed low while nMode stays low → all outputs 0 during reset; ModeHeld re-asserts 4 cycles after reset release; no ModeLong fires before 16 further cycles.
